// File: rtl/qspi_target.sv
// QSPI responder: oversamples the initiator's sck/chip selects/mosi and turns register and
// SMEM transactions into single-cycle local bus strobes, returning read data on miso.
module qspi_target #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          TAT_CLKS     = 16,
    parameter logic [31:0] RD_FAIL_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sck,
    input  logic        hcsn,
    input  logic        bcsn,
    input  logic [3:0]  mosi,
    output logic [3:0]  miso,
    output logic        miso_oe,
    output logic        bus_wr,
    output logic        bus_rd,
    output logic        bus_bank,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic        evt_abort,
    output logic        evt_bad_opcode,
    output logic        evt_rd_timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPCODE = 3'd1,
        ADDR   = 3'd2,
        WDATA  = 3'd3,
        TAT    = 3'd4,
        RDATA  = 3'd5,
        DONE   = 3'd6,
        IGNORE = 3'd7
    } state_t;

    localparam logic [4:0] TAT_LAST = 5'(TAT_CLKS);

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Input synchronizers; chip selects reset to their inactive (high) level.
    logic [SYNC_STAGES-1:0]      sck_sr;
    logic [SYNC_STAGES-1:0]      hcsn_sr;
    logic [SYNC_STAGES-1:0]      bcsn_sr;
    logic [SYNC_STAGES-1:0][3:0] mosi_sr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sr  <= '0;
            hcsn_sr <= '1;
            bcsn_sr <= '1;
            mosi_sr <= '0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            hcsn_sr <= {hcsn_sr[SYNC_STAGES-2:0], hcsn};
            bcsn_sr <= {bcsn_sr[SYNC_STAGES-2:0], bcsn};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
        end
    end

    logic       sck_s, hcsn_s, bcsn_s;
    logic [3:0] mosi_s;
    logic       sck_d, cs_d;
    logic       cs_active, cs_on, rise, fall;

    assign sck_s     = sck_sr[SYNC_STAGES-1];
    assign hcsn_s    = hcsn_sr[SYNC_STAGES-1];
    assign bcsn_s    = bcsn_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign cs_active = ~hcsn_s | ~bcsn_s;
    assign cs_on     = cs_active & ~cs_d;
    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            sck_d <= sck_s;
            cs_d  <= cs_active;
        end
    end

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [27:0] sr;
    logic        op_read, op_burst, widx;
    logic [31:0] addr;
    logic [31:0] w0, w1;
    logic        w0_ok, w1_ok;
    logic        rd_pend, rd_idx, rd2_req;
    logic [31:0] tx;

    logic        last8;
    logic [7:0]  op_in;
    logic [31:0] word_in;
    logic        op_known;

    // Wire word is MSB-first nybbles; the bus value is that register byte-reversed.
    assign last8    = (cnt == 5'd7);
    assign op_in    = {sr[6:0], mosi_s[0]};
    assign word_in  = bswap({sr, mosi_s});
    assign op_known = (op_in[7:2] == 6'b111010);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (cs_on) state_nxt = OPCODE;
        end else if (!cs_active) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                OPCODE: if (rise && last8) state_nxt = op_known ? ADDR : IGNORE;
                ADDR:   if (rise && last8) state_nxt = op_read ? TAT : WDATA;
                WDATA:  if (rise && last8 && (!op_burst || widx)) state_nxt = DONE;
                TAT:    if (fall && cnt == TAT_LAST) state_nxt = RDATA;
                RDATA:  if (rise && cnt == (op_burst ? 5'd15 : 5'd7)) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    logic set_abort, set_bad_op, set_rd0, set_wr;
    logic ld_w0, ld_w1, shift_tx, drop_oe;

    always_comb begin
        set_abort  = 1'b0;
        set_bad_op = 1'b0;
        set_rd0    = 1'b0;
        set_wr     = 1'b0;
        ld_w0      = 1'b0;
        ld_w1      = 1'b0;
        shift_tx   = 1'b0;
        drop_oe    = 1'b0;
        if (state != IDLE && state != DONE && state != IGNORE && !cs_active) begin
            set_abort = 1'b1;
        end else begin
            case (state)
                OPCODE: set_bad_op = rise && last8 && !op_known;
                ADDR:   set_rd0    = rise && last8 && op_read;
                WDATA:  set_wr     = rise && last8;
                TAT:    ld_w0      = fall && (cnt == TAT_LAST);
                RDATA: begin
                    ld_w1    = fall && op_burst && (cnt == 5'd8);
                    shift_tx = fall && !(op_burst && (cnt == 5'd8));
                end
                DONE, IGNORE: drop_oe = fall;
                default: ;
            endcase
        end
    end

    // bus_rd is a one-cycle request; the single bus_rvalid that follows (any latency)
    // answers the oldest outstanding request, and is dropped when none is outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt            <= '0;
            sr             <= '0;
            op_read        <= 1'b0;
            op_burst       <= 1'b0;
            widx           <= 1'b0;
            addr           <= '0;
            w0             <= '0;
            w1             <= '0;
            w0_ok          <= 1'b0;
            w1_ok          <= 1'b0;
            rd_pend        <= 1'b0;
            rd_idx         <= 1'b0;
            rd2_req        <= 1'b0;
            tx             <= '0;
            miso_oe        <= 1'b0;
            bus_wr         <= 1'b0;
            bus_rd         <= 1'b0;
            bus_bank       <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            evt_abort      <= 1'b0;
            evt_bad_opcode <= 1'b0;
            evt_rd_timeout <= 1'b0;
        end else begin
            bus_wr         <= 1'b0;
            bus_rd         <= 1'b0;
            evt_abort      <= set_abort;
            evt_bad_opcode <= set_bad_op;
            evt_rd_timeout <= 1'b0;

            if (rise) sr <= (state == OPCODE) ? {sr[26:0], mosi_s[0]} : {sr[23:0], mosi_s};

            if (state_nxt != state || set_wr)
                cnt <= '0;
            else if (rise && !(state == TAT && cnt == TAT_LAST))
                cnt <= cnt + 5'd1;

            if (state == IDLE && cs_on) begin
                bus_bank <= ~bcsn_s;
                widx     <= 1'b0;
                w0_ok    <= 1'b0;
                w1_ok    <= 1'b0;
            end
            if (state == OPCODE && state_nxt == ADDR) begin
                op_read  <= ~op_in[0];
                op_burst <= op_in[1];
            end
            if (state == ADDR && (state_nxt == TAT || state_nxt == WDATA)) addr <= word_in;

            if (set_rd0) begin
                bus_rd   <= 1'b1;
                bus_addr <= word_in;
                rd_pend  <= 1'b1;
                rd_idx   <= 1'b0;
            end
            if (set_wr) begin
                bus_wr    <= 1'b1;
                bus_addr  <= widx ? addr + 32'd4 : addr;
                bus_wdata <= word_in;
                widx      <= ~widx;
            end
            if (rd2_req) begin
                bus_rd   <= 1'b1;
                bus_addr <= addr + 32'd4;
                rd_pend  <= 1'b1;
                rd_idx   <= 1'b1;
                rd2_req  <= 1'b0;
            end
            if (bus_rvalid && rd_pend) begin
                rd_pend <= 1'b0;
                if (!rd_idx) begin
                    w0      <= bus_rdata;
                    w0_ok   <= 1'b1;
                    rd2_req <= op_burst;
                end else begin
                    w1    <= bus_rdata;
                    w1_ok <= 1'b1;
                end
            end

            // A word missing at its first fall is replaced; its response is then stale.
            if (ld_w0 || ld_w1) begin
                if (ld_w0) miso_oe <= 1'b1;
                if ((ld_w0 && w0_ok) || (ld_w1 && w1_ok)) begin
                    tx <= bswap(ld_w0 ? w0 : w1);
                end else begin
                    tx             <= bswap(RD_FAIL_DATA);
                    evt_rd_timeout <= 1'b1;
                    rd_pend        <= 1'b0;
                    rd2_req        <= 1'b0;
                end
            end
            if (shift_tx) tx <= {tx[27:0], 4'h0};
            if (drop_oe)  miso_oe <= 1'b0;

            if (state_nxt == IDLE) begin
                rd_pend <= 1'b0;
                rd2_req <= 1'b0;
                bus_rd  <= 1'b0;
                miso_oe <= 1'b0;
            end
        end
    end

    assign miso = miso_oe ? tx[31:28] : 4'h0;

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: a bit-banged QSPI initiator plus a small register model.
module tb_qspi_target;
  localparam int TAT = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sck = 1'b0;
  logic        hcsn = 1'b1;
  logic        bcsn = 1'b1;
  logic [3:0]  mosi = 4'h0;
  logic [3:0]  miso;
  logic        miso_oe;
  logic        bus_wr, bus_rd, bus_bank;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_rvalid = 1'b0;
  logic        evt_abort, evt_bad_opcode, evt_rd_timeout;

  int checks = 0;
  int errors = 0;

  qspi_target #(.SYNC_STAGES(2), .TAT_CLKS(TAT), .RD_FAIL_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn), .sck(sck), .hcsn(hcsn), .bcsn(bcsn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_bank(bus_bank),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .evt_abort(evt_abort), .evt_bad_opcode(evt_bad_opcode), .evt_rd_timeout(evt_rd_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register model and bus monitor
  logic [31:0] mem [16];
  int          rsp_delay = 3;
  logic [31:0] rsp_addr;
  int          n_wr, n_rd, n_abort, n_bad, n_tmo;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic        wr_bank_q[$];
  logic [31:0] rd_addr_q[$];

  always @(negedge clk) begin
    if (bus_wr === 1'b1) begin
      n_wr++;
      wr_addr_q.push_back(bus_addr);
      wr_data_q.push_back(bus_wdata);
      wr_bank_q.push_back(bus_bank);
      mem[bus_addr[5:2]] = bus_wdata;
    end
    if (bus_rd === 1'b1) begin
      n_rd++;
      rd_addr_q.push_back(bus_addr);
    end
    if (evt_abort === 1'b1) n_abort++;
    if (evt_bad_opcode === 1'b1) n_bad++;
    if (evt_rd_timeout === 1'b1) n_tmo++;
  end

  always begin
    @(negedge clk);
    if (bus_rd === 1'b1) begin
      rsp_addr = bus_addr;
      repeat (rsp_delay - 1) @(negedge clk);
      bus_rdata  = mem[rsp_addr[5:2]];
      bus_rvalid = 1'b1;
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
    end
  end

  // driver tasks
  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_wr = 0; n_rd = 0; n_abort = 0; n_bad = 0; n_tmo = 0;
    wr_addr_q.delete(); wr_data_q.delete(); wr_bank_q.delete(); rd_addr_q.delete();
  endtask

  task automatic sck_pulse(input logic [3:0] nyb);
    mosi = nyb;
    tick(8);
    sck = 1'b1;
    tick(8);
    sck = 1'b0;
  endtask

  task automatic cs_assert(input bit bank);
    if (bank) bcsn = 1'b0;
    else      hcsn = 1'b0;
    tick(4);
  endtask

  task automatic cs_release();
    tick(4);
    hcsn = 1'b1;
    bcsn = 1'b1;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] op);
    for (int i = 0; i < 8; i++) sck_pulse({3'b000, op[7-i]});
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] s;
    s = bswap(w);
    for (int i = 0; i < 8; i++) sck_pulse(s[31-4*i -: 4]);
  endtask

  task automatic read_word(output logic [31:0] w, inout bit oe_low_seen);
    logic [31:0] s;
    s = '0;
    mosi = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(8);
      if (miso_oe !== 1'b1) oe_low_seen = 1'b1;
      s = {s[27:0], miso};
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
    end
    w = bswap(s);
  endtask

  task automatic do_read(input bit bank, input logic [31:0] a, input bit burst,
                         output logic [31:0] w0, output logic [31:0] w1,
                         output bit oe_low_seen, output logic oe_after);
    oe_low_seen = 1'b0;
    w1 = '0;
    cs_assert(bank);
    send_byte(burst ? 8'hEA : 8'hE8);
    send_word(a);
    for (int i = 0; i < TAT; i++) sck_pulse(4'h0);
    read_word(w0, oe_low_seen);
    if (burst) read_word(w1, oe_low_seen);
    tick(6);
    oe_after = miso_oe;
    cs_release();
  endtask

  task automatic do_write(input bit bank, input logic [31:0] a, input logic [31:0] d);
    cs_assert(bank);
    send_byte(8'hE9);
    send_word(a);
    send_word(d);
    cs_release();
  endtask

  // scenarios
  task automatic test_reset();
    tick(3);
    checks++;
    if ({miso_oe, bus_wr, bus_rd, bus_bank, evt_abort, evt_bad_opcode, evt_rd_timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {miso_oe, bus_wr, bus_rd, bus_bank, evt_abort, evt_bad_opcode, evt_rd_timeout});
    end
    resetn = 1'b1;
    tick(4);
    checks++;
    if (miso !== 4'h0) begin errors++; $display("FAIL reset_miso: got %h expected 0", miso); end
    checks++;
    if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus_addr); end
    checks++;
    if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus_wdata); end
  endtask

  task automatic test_write_single();
    clear_mon();
    do_write(1'b0, 32'h0000_0010, 32'h1234_5678);
    checks++;
    if (n_wr !== 1) begin errors++; $display("FAIL whr_count: got %0d expected 1", n_wr); end
    checks++;
    if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx) !== 32'h10) begin
      errors++; $display("FAIL whr_addr: got %h expected 00000010", wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx);
    end
    checks++;
    if ((wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx) !== 32'h1234_5678) begin
      errors++; $display("FAIL whr_data: got %h expected 12345678", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx);
    end
    checks++;
    if ((wr_bank_q.size() > 0 ? wr_bank_q[0] : 1'bx) !== 1'b0) begin
      errors++; $display("FAIL whr_bank: got %b expected 0", wr_bank_q.size() > 0 ? wr_bank_q[0] : 1'bx);
    end
    checks++;
    if (n_rd + n_abort + n_bad + n_tmo !== 0) begin
      errors++; $display("FAIL whr_side: got %0d other pulses expected 0", n_rd + n_abort + n_bad + n_tmo);
    end
  endtask

  task automatic test_read_single();
    logic [31:0] w0, w1;
    bit          oe_low;
    logic        oe_after;
    clear_mon();
    mem[1] = 32'hCAFE_F00D;
    rsp_delay = 3;
    do_read(1'b0, 32'h0000_0004, 1'b0, w0, w1, oe_low, oe_after);
    checks++;
    if (n_rd !== 1) begin errors++; $display("FAIL rhr_count: got %0d expected 1", n_rd); end
    checks++;
    if ((rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hx) !== 32'h4) begin
      errors++; $display("FAIL rhr_addr: got %h expected 00000004", rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hx);
    end
    checks++;
    if (w0 !== 32'hCAFE_F00D) begin errors++; $display("FAIL rhr_data: got %h expected cafef00d", w0); end
    checks++;
    if (oe_low !== 1'b0) begin errors++; $display("FAIL rhr_oe_during: got low expected high"); end
    checks++;
    if (oe_after !== 1'b0) begin errors++; $display("FAIL rhr_oe_after: got %b expected 0", oe_after); end
    checks++;
    if (n_tmo + n_abort !== 0) begin errors++; $display("FAIL rhr_events: got %0d expected 0", n_tmo + n_abort); end
  endtask

  task automatic test_write_burst();
    clear_mon();
    cs_assert(1'b1);
    send_byte(8'hEB);
    send_word(32'hFFFF_FFFC);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    cs_release();
    checks++;
    if (n_wr !== 2) begin errors++; $display("FAIL wburst_count: got %0d expected 2", n_wr); end
    checks++;
    if ((wr_addr_q.size() > 1 ? {wr_addr_q[0], wr_addr_q[1]} : 64'hx) !== {32'hFFFF_FFFC, 32'h0}) begin
      errors++; $display("FAIL wburst_addr: got %h expected fffffffc00000000",
                         wr_addr_q.size() > 1 ? {wr_addr_q[0], wr_addr_q[1]} : 64'hx);
    end
    checks++;
    if ((wr_data_q.size() > 1 ? {wr_data_q[0], wr_data_q[1]} : 64'hx) !== {32'h1, 32'h2}) begin
      errors++; $display("FAIL wburst_data: got %h expected 0000000100000002",
                         wr_data_q.size() > 1 ? {wr_data_q[0], wr_data_q[1]} : 64'hx);
    end
    checks++;
    if ((wr_bank_q.size() > 1 ? {wr_bank_q[0], wr_bank_q[1]} : 2'bxx) !== 2'b11) begin
      errors++; $display("FAIL wburst_bank: got %b expected 11", wr_bank_q.size() > 1 ? {wr_bank_q[0], wr_bank_q[1]} : 2'bxx);
    end
  endtask

  task automatic test_read_burst();
    logic [31:0] w0, w1;
    bit          oe_low;
    logic        oe_after;
    clear_mon();
    rsp_delay = 3;
    // mem[0]=2 from the wrapped burst write, mem[1]=cafef00d
    do_read(1'b1, 32'h0000_0000, 1'b1, w0, w1, oe_low, oe_after);
    checks++;
    if ((rd_addr_q.size() > 1 ? {rd_addr_q[0], rd_addr_q[1]} : 64'hx) !== {32'h0, 32'h4}) begin
      errors++; $display("FAIL rburst_addr: got %h expected 0000000000000004",
                         rd_addr_q.size() > 1 ? {rd_addr_q[0], rd_addr_q[1]} : 64'hx);
    end
    checks++;
    if ({w0, w1} !== {32'h0000_0002, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL rburst_data: got %h %h expected 00000002 cafef00d", w0, w1);
    end
    checks++;
    if ({oe_low, oe_after, n_tmo[0]} !== 3'b000) begin
      errors++; $display("FAIL rburst_oe: got %b%b tmo %0d expected 00 0", oe_low, oe_after, n_tmo);
    end
  endtask

  task automatic test_read_timeout();
    logic [31:0] w0, w1;
    bit          oe_low;
    logic        oe_after;
    clear_mon();
    mem[2] = 32'h1111_2222;
    rsp_delay = 300;
    do_read(1'b0, 32'h0000_0008, 1'b0, w0, w1, oe_low, oe_after);
    tick(40);
    rsp_delay = 3;
    checks++;
    if (w0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_data: got %h expected ffffffff", w0); end
    checks++;
    if (n_tmo !== 1) begin errors++; $display("FAIL tmo_count: got %0d expected 1", n_tmo); end
    checks++;
    if (n_rd !== 1) begin errors++; $display("FAIL tmo_rd_count: got %0d expected 1", n_rd); end
    clear_mon();
    do_read(1'b0, 32'h0000_0008, 1'b0, w0, w1, oe_low, oe_after);
    checks++;
    if (w0 !== 32'h1111_2222) begin errors++; $display("FAIL tmo_recover: got %h expected 11112222", w0); end
  endtask

  task automatic test_bad_opcode();
    clear_mon();
    cs_assert(1'b0);
    send_byte(8'h5A);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0BAD_0BAD);
    cs_release();
    checks++;
    if (n_bad !== 1) begin errors++; $display("FAIL badop_count: got %0d expected 1", n_bad); end
    checks++;
    if (n_wr + n_rd + n_abort !== 0) begin
      errors++; $display("FAIL badop_strobes: got %0d expected 0", n_wr + n_rd + n_abort);
    end
    clear_mon();
    do_write(1'b0, 32'h0000_0020, 32'hA5A5_0F0F);
    checks++;
    if ((n_wr == 1 && wr_addr_q.size() > 0 ? {wr_addr_q[0], wr_data_q[0]} : 64'hx) !== {32'h20, 32'hA5A5_0F0F}) begin
      errors++; $display("FAIL badop_next: got %0d writes expected one 00000020=a5a50f0f", n_wr);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    cs_assert(1'b0);
    send_byte(8'hE9);
    for (int i = 0; i < 4; i++) sck_pulse(4'h3);
    cs_release();
    checks++;
    if (n_abort !== 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", n_abort); end
    checks++;
    if (n_wr + n_rd + n_bad !== 0 || miso_oe !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got %0d strobes oe %b expected 0 0", n_wr + n_rd + n_bad, miso_oe);
    end
  endtask

  task automatic test_reset_mid_rdata();
    logic [31:0] w0, w1;
    bit          oe_low;
    logic        oe_after;
    rsp_delay = 3;
    cs_assert(1'b0);
    send_byte(8'hE8);
    send_word(32'h0000_0010);
    for (int i = 0; i < TAT; i++) sck_pulse(4'h0);
    for (int i = 0; i < 3; i++) sck_pulse(4'h0);
    tick(4);
    checks++;
    if (miso_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_oe_before: got %b expected 1", miso_oe); end
    clear_mon();
    resetn = 1'b0;
    hcsn = 1'b1;
    tick(2);
    checks++;
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b expected 0", miso_oe); end
    resetn = 1'b1;
    tick(12);
    checks++;
    if (n_wr + n_rd + n_abort + n_bad + n_tmo !== 0) begin
      errors++; $display("FAIL rst_mid_pulses: got %0d expected 0", n_wr + n_rd + n_abort + n_bad + n_tmo);
    end
    clear_mon();
    do_read(1'b0, 32'h0000_0010, 1'b0, w0, w1, oe_low, oe_after);
    checks++;
    if (w0 !== 32'h1234_5678 || n_rd !== 1) begin
      errors++; $display("FAIL rst_mid_next: got %h reads %0d expected 12345678 reads 1", w0, n_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    clear_mon();
    test_reset();
    test_write_single();
    test_read_single();
    test_write_burst();
    test_read_burst();
    test_read_timeout();
    test_bad_opcode();
    test_abort();
    test_reset_mid_rdata();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
